// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write controller.
package rf_ctrl_pkg;

    localparam int NUM_REGS  = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    // R0 is hardwired to zero; writes to it are accepted and discarded.
    localparam logic [RF_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        ST_CLEAR,
        ST_ARB
    } state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of writeback request lanes plus the register-file write port.
// master: the requester/register-file side; slave: the arbiter.
interface rf_write_arbiter_if
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   rf_wr_en;
    logic [ADDR_W-1:0]      rf_wr_addr;
    logic [DATA_W-1:0]      rf_wr_data;
    logic                   busy;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request strictly after
// ptr (wrapping modulo NREQ) wins. ptr is the index of the last winner.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // Scan NREQ positions starting one past the last winner; first hit wins.
    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register-file write port between NREQ
// writeback sources, with a registered write stage (1-cycle latency).
// Optional feature macro RF_CLEAR_EN: after reset, zero all registers
// (one write per cycle, addr 0..31) before arbitration starts.
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef RF_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_ARB;
`endif

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic               wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]  wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0]  wr_data_reg, wr_data_next;

    logic [NREQ-1:0]    grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic               accept;

    logic [ADDR_W-1:0]  lane_addr [NREQ];
    logic [DATA_W-1:0]  lane_data [NREQ];

    // Unpack the flat request buses into per-lane arrays for indexed muxing.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign lane_data[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_reg),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Grants are only visible while arbitrating; a grant implies valid.
    assign bus.req_ready = (state_reg == ST_ARB) ? grant : '0;
    assign accept        = grant_any && (state_reg == ST_ARB);

`ifdef RF_CLEAR_EN
    logic [RF_ADDR_W-1:0] clr_cnt_reg;
    logic                 clr_last;

    assign clr_last = (clr_cnt_reg == RF_ADDR_W'(NUM_REGS - 1));
    assign bus.busy = (state_reg == ST_CLEAR);

    // Clear address counter: walks 0..31 while clearing, parked at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
        end
    end
`else
    assign bus.busy = 1'b0;
`endif

    // FSM next state: leave CLEAR once the last register has been issued.
    always_comb begin
        state_next = state_reg;
`ifdef RF_CLEAR_EN
        if (state_reg == ST_CLEAR && clr_last) begin
            state_next = ST_ARB;
        end
`endif
    end

    // Next value of the write stage and round-robin pointer.
    always_comb begin
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        rr_ptr_next  = rr_ptr_reg;
`ifdef RF_CLEAR_EN
        if (state_reg == ST_CLEAR) begin
            wr_en_next   = 1'b1;
            wr_addr_next = ADDR_W'(clr_cnt_reg);
            wr_data_next = '0;
        end else
`endif
        if (accept) begin
            // R0 writes are consumed but never reach the register file.
            wr_en_next   = (lane_addr[grant_idx] != ADDR_W'(ZERO_REG));
            wr_addr_next = lane_addr[grant_idx];
            wr_data_next = lane_data[grant_idx];
            rr_ptr_next  = grant_idx;
        end
    end

    // State, pointer and output registers; reset drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= RESET_STATE;
            rr_ptr_reg  <= PTR_W'(NREQ - 1);
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    assign bus.rf_wr_en   = wr_en_reg;
    assign bus.rf_wr_addr = wr_addr_reg;
    assign bus.rf_wr_data = wr_data_reg;

endmodule
